uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning pointer width.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port resetq  input  1  synchronous active-low reset.
REQ-006 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-007 SHALL have port rx_valid  input  1  receiver holds a byte.
REQ-008 SHALL have port rx_rd  output  1  registered one-cycle acknowledge to the receiver (clears its valid).
REQ-009 SHALL have port pop  input  1  consumer removes head entry this cycle.
REQ-010 SHALL have port dout  output  8  head entry, 8'h00 when empty.
REQ-011 SHALL have port empty  output  1  no entries.
REQ-012 SHALL have port full  output  1  DEPTH entries.
REQ-013 SHALL have port count  output  AW+1  current occupancy.
REQ-014 SHALL have port overrun  output  1  sticky: byte dropped while full.
REQ-015 SHALL have port clr_ovr  input  1  clears overrun.
REQ-016 SHALL have port brk  output  1  one-cycle break pulse (see Configuration).

Function
REQ-017 SHALL treat a byte as offered in any cycle where rx_valid=1 and rx_rd=0; rx_rd SHALL be 1 in exactly the following cycle.
REQ-018 SHALL NOT offer a byte while rx_rd=1, even if rx_valid is still 1, so each received byte is taken at most once.
REQ-019 SHALL write an offered byte at the tail on that edge when not full, making it visible on dout/count the next cycle (1-cycle push latency).
REQ-020 SHALL, when an offered byte meets full and no pop occurs, drop the byte, set overrun, and still assert rx_rd.
REQ-021 SHALL present dout combinationally from the head (first-word fall-through); pop removes the head on the edge.
REQ-022 SHALL ignore pop when empty, including pop coinciding with an offer into an empty FIFO: the byte is stored, count becomes 1.
REQ-023 SHALL, on simultaneous offer and pop while full, accept both: count stays DEPTH, overrun unchanged.
REQ-024 SHALL, on simultaneous offer and pop otherwise, keep count unchanged.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; full/empty derive from count, never from pointer equality alone.
REQ-026 SHALL clear overrun on clr_ovr; a set event in the same cycle SHALL win.

Reset
REQ-027 SHALL, on resetq=0 at an edge, set pointers and count to 0, empty=1, full=0, overrun=0, rx_rd=0, brk=0, dout=8'h00; storage contents are don't-care.
REQ-028 SHALL ignore offers and pops in a reset cycle; a byte held by the receiver across reset SHALL be taken on the first cycle after release.

Configuration
REQ-029 SHALL compile the break feature only when macro UART_RX_FIFO_BRK_EN is defined.
REQ-030 SHALL, with UART_RX_FIFO_BRK_EN, on acceptance of byte 8'h03 (Ctrl-C): not store it, flush the FIFO (count 0), clear overrun, ignore a same-cycle pop, and pulse brk for one cycle after the edge.
REQ-031 SHALL, without UART_RX_FIFO_BRK_EN, store 8'h03 like any other byte and tie brk to 0.

Structure
REQ-032 SHALL take UART_DATA_W=8 and BRK_CHAR=8'h03 from shared package uart_pkg.
REQ-033 SHALL place storage in sub-module uart_fifo_ram: DEPTH x 8 register array, one synchronous write port, one asynchronous read port; pointer/count/handshake logic stays in uart_rx_fifo.

Verification
REQ-034 SHALL cover: offer 8'h41 for 3 cycles held valid -> exactly one rx_rd pulse, count=1, dout=8'h41.
REQ-035 SHALL cover: 17 bytes 0x00..0x10 into DEPTH=16, no pop -> full=1, overrun=1, 17 rx_rd pulses, pops return 0x00..0x0F in order.
REQ-036 SHALL cover: full FIFO, offer 0x55 with pop -> count stays 16, 0x55 is the last popped byte, overrun=0.
REQ-037 SHALL cover: empty FIFO, offer 0x7E with pop -> count=1, dout=0x7E; 40 push/pop cycles with wrap -> data order preserved.
REQ-038 SHALL cover: 5 bytes stored then 8'h03 -> with macro: brk pulses 1 cycle, count=0, empty=1; without: count=6, brk=0.
REQ-039 SHALL cover: resetq=0 mid-stream at count=7 with overrun=1 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants for the receive path.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam logic [UART_DATA_W-1:0] BRK_CHAR = 8'h03;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x byte register array, synchronous write port, asynchronous read port.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UART_DATA_W-1:0] rdata
);
    logic [UART_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through byte FIFO behind a UART receiver with sticky overrun.
// Define UART_RX_FIFO_BRK_EN to turn a received Ctrl-C into a flush plus one-cycle brk pulse.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   resetq,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_valid,
    output logic                   rx_rd,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   empty,
    output logic                   full,
    output logic [AW:0]            count,
    output logic                   overrun,
    input  logic                   clr_ovr,
    output logic                   brk
);
    logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovr_q, ovr_d, rd_q, rd_d;
    logic                   offer, is_brk, do_push, do_pop, ovr_set;
    logic [UART_DATA_W-1:0] ram_rd;

    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(DEPTH);

    always_comb begin
        // the acknowledge cycle blocks a second take of the same byte
        offer   = rx_valid && !rd_q;
`ifdef UART_RX_FIFO_BRK_EN
        is_brk  = offer && rx_data == BRK_CHAR;
`else
        is_brk  = 1'b0;
`endif
        do_pop  = pop && !empty && !is_brk;
        do_push = offer && (!full || do_pop) && !is_brk;
        ovr_set = offer && full && !do_pop && !is_brk;
        wptr_d  = is_brk ? '0 : wptr_q + AW'(do_push);
        rptr_d  = is_brk ? '0 : rptr_q + AW'(do_pop);
        count_d = is_brk ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        ovr_d   = is_brk ? 1'b0 : ovr_set ? 1'b1 : clr_ovr ? 1'b0 : ovr_q;
        rd_d    = offer;
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            rd_q    <= rd_d;
        end
    end

`ifdef UART_RX_FIFO_BRK_EN
    logic brk_q, brk_d;
    assign brk_d = is_brk;
    always_ff @(posedge clk) begin
        if (!resetq) brk_q <= 1'b0;
        else         brk_q <= brk_d;
    end
    assign brk = brk_q;
`else
    assign brk = 1'b0;
`endif

    uart_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (wptr_q),
        .wdata (rx_data),
        .raddr (rptr_q),
        .rdata (ram_rd)
    );

    assign dout    = empty ? '0 : ram_rd;
    assign count   = count_q;
    assign overrun = ovr_q;
    assign rx_rd   = rd_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized scenarios checked against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW = 4;
`ifdef UART_RX_FIFO_BRK_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetq, rx_valid, pop, clr_ovr;
    logic [7:0]    rx_data;
    logic          rx_rd, empty, full, overrun, brk;
    logic [7:0]    dout;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic m_ovr = 1'b0, m_rd = 1'b0, m_brk = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_rd(rx_rd), .pop(pop), .dout(dout), .empty(empty), .full(full),
        .count(count), .overrun(overrun), .clr_ovr(clr_ovr), .brk(brk)
    );

    // advance the model by one clock with the current inputs, then step the DUT
    task automatic tick();
        bit offer, popping, was_full, flush;
        offer = rx_valid && !m_rd;
        if (!resetq) begin
            q.delete();
            m_ovr = 1'b0;
            m_rd  = 1'b0;
            m_brk = 1'b0;
        end else begin
            flush    = BRK && offer && rx_data == 8'h03;
            was_full = q.size() == DEPTH;
            popping  = pop && q.size() != 0 && !flush;
            m_brk    = flush;
            m_rd     = offer;
            if (flush) begin
                q.delete();
                m_ovr = 1'b0;
            end else begin
                if (offer && was_full && !popping) m_ovr = 1'b1;
                else if (clr_ovr) m_ovr = 1'b0;
                if (popping) void'(q.pop_front());
                if (offer && (!was_full || popping)) q.push_back(rx_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        return b == 8'h03 ? 8'h30 : b;
    endfunction

    task automatic send_byte(input logic [7:0] b, output int pulse);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        pulse    = int'(rx_rd);
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic drain();
        pop = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        resetq = 1'b0; rx_valid = 1'b0; pop = 1'b0; clr_ovr = 1'b0; rx_data = 8'h00;
        tick();
        tick();
        checks++;
        if ({empty, full, count, dout, rx_rd, overrun, brk} !== {1'b1, 1'b0, 5'd0, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset e/f/cnt/dout/rd/ovr/brk got %b %b %0d %h %b %b %b want 1 0 0 00 0 0 0",
                     empty, full, count, dout, rx_rd, overrun, brk);
        end
        resetq = 1'b1;
        tick();
    endtask

    task automatic test_hold_valid();
        int pulses = 0;
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        tick();
        pulses += int'(rx_rd);
        tick();
        pulses += int'(rx_rd);
        rx_valid = 1'b0;
        tick();
        pulses += int'(rx_rd);
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", pulses); end
        checks++;
        if (count !== 5'd1 || count !== 5'(q.size())) begin
            errors++; $display("FAIL hold_count got %0d want 1 (model %0d)", count, q.size());
        end
        checks++;
        if (dout !== 8'h41) begin errors++; $display("FAIL hold_dout got %h want 41", dout); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checks++;
        if (empty !== 1'b1 || dout !== 8'h00) begin
            errors++; $display("FAIL hold_pop empty=%b dout=%h want 1 00", empty, dout);
        end
    endtask

    task automatic test_fill_overrun();
        int pulses = 0, p;
        for (int i = 0; i <= 16; i++) begin
            send_byte(8'(i), p);
            pulses += p;
        end
        checks++;
        if (pulses != 17) begin errors++; $display("FAIL fill_pulses got %0d want 17", pulses); end
        checks++;
        if ({full, overrun, count} !== {1'b1, 1'b1, 5'd16}) begin
            errors++; $display("FAIL fill_state full=%b ovr=%b cnt=%0d want 1 1 16", full, overrun, count);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dout !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d] got %h want %h", i, dout, 8'(i)); end
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        checks++;
        if (empty !== 1'b1 || overrun !== 1'b1) begin
            errors++; $display("FAIL fill_drained empty=%b ovr=%b want 1 1", empty, overrun);
        end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL clr_ovr got %b want 0", overrun); end
    endtask

    task automatic test_full_push_pop();
        int p;
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) send_byte(rand_byte(), p);
        rx_data = 8'hAA; rx_valid = 1'b1; clr_ovr = 1'b1;
        tick();
        rx_valid = 1'b0; clr_ovr = 1'b0;
        checks++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL set_beats_clr ovr=%b cnt=%0d want 1 16", overrun, count);
        end
        tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        rx_data = 8'h55; rx_valid = 1'b1; pop = 1'b1;
        tick();
        rx_valid = 1'b0; pop = 1'b0;
        tick();
        checks++;
        if ({count, overrun, full} !== {5'd16, 1'b0, 1'b1}) begin
            errors++; $display("FAIL full_pushpop cnt=%0d ovr=%b full=%b want 16 0 1", count, overrun, full);
        end
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dout !== q[0]) begin errors++; $display("FAIL full_drain[%0d] got %h want %h", i, dout, q[0]); end
            last = dout;
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        checks++;
        if (last !== 8'h55) begin errors++; $display("FAIL full_last got %h want 55", last); end
    endtask

    task automatic test_empty_push_pop();
        rx_data = 8'h7E; rx_valid = 1'b1; pop = 1'b1;
        tick();
        rx_valid = 1'b0; pop = 1'b0;
        checks++;
        if (count !== 5'd1 || dout !== 8'h7E) begin
            errors++; $display("FAIL empty_pushpop cnt=%0d dout=%h want 1 7e", count, dout);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            rx_data  = rand_byte();
            rx_valid = 1'b1;
            pop      = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (dout !== (q.size() != 0 ? q[0] : 8'h00) || count !== 5'(q.size()) || rx_rd !== m_rd) begin
                errors++;
                $display("FAIL wrap[%0d] dout=%h cnt=%0d rd=%b want %h %0d %b", i, dout, count, rx_rd,
                         q.size() != 0 ? q[0] : 8'h00, q.size(), m_rd);
            end
        end
        rx_valid = 1'b0; pop = 1'b0;
        tick();
        while (q.size() != 0) begin
            checks++;
            if (dout !== q[0]) begin errors++; $display("FAIL wrap_drain got %h want %h", dout, q[0]); end
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", empty); end
    endtask

    task automatic test_break();
        int p;
        drain();
        for (int i = 0; i < 5; i++) send_byte(rand_byte(), p);
        rx_data = 8'h03; rx_valid = 1'b1; pop = 1'b1;
        tick();
        rx_valid = 1'b0; pop = 1'b0;
`ifdef UART_RX_FIFO_BRK_EN
        checks++;
        if ({brk, count, empty} !== {1'b1, 5'd0, 1'b1}) begin
            errors++; $display("FAIL brk_flush brk=%b cnt=%0d empty=%b want 1 0 1", brk, count, empty);
        end
`else
        checks++;
        if ({brk, count} !== {1'b0, 5'd5}) begin
            errors++; $display("FAIL brk_store brk=%b cnt=%0d want 0 5", brk, count);
        end
`endif
        tick();
        checks++;
        if (brk !== 1'b0 || count !== 5'(q.size()) || (!BRK && count !== 5'd5)) begin
            errors++; $display("FAIL brk_after brk=%b cnt=%0d model %0d", brk, count, q.size());
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int p;
        for (int i = 0; i <= DEPTH; i++) send_byte(rand_byte(), p);
        pop = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        pop = 1'b0;
        checks++;
        if (count !== 5'd7 || overrun !== 1'b1) begin
            errors++; $display("FAIL pre_reset cnt=%0d ovr=%b want 7 1", count, overrun);
        end
        resetq = 1'b0; rx_data = 8'h5A; rx_valid = 1'b1; pop = 1'b1;
        tick();
        checks++;
        if ({empty, full, count, dout, rx_rd, overrun, brk} !== {1'b1, 1'b0, 5'd0, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL mid_reset e/f/cnt/dout/rd/ovr/brk got %b %b %0d %h %b %b %b want 1 0 0 00 0 0 0",
                     empty, full, count, dout, rx_rd, overrun, brk);
        end
        resetq = 1'b1; pop = 1'b0;
        tick();
        rx_valid = 1'b0;
        checks++;
        if ({rx_rd, count, dout} !== {1'b1, 5'd1, 8'h5A}) begin
            errors++; $display("FAIL post_reset rd=%b cnt=%0d dout=%h want 1 1 5a", rx_rd, count, dout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_hold_valid();
        test_fill_overrun();
        test_full_push_pop();
        test_empty_push_pop();
        test_break();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
